// File: rtl/instr_sequencer.sv
// Four-state instruction sequencer: drives an external ALU and a simple memory port,
// and owns an 8x8 register file plus carry/zero flags.
module instr_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       CLK,
  input  logic       reset_n,
  input  logic       instr_valid,
  input  logic [8:0] instr,
  output logic       instr_ready,
  output logic [2:0] alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_ci,
  output logic       alu_rsh,
  input  logic [7:0] alu_rslt,
  input  logic       alu_co,
  input  logic       alu_z,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack,
  output logic       done,
  output logic       err,
  output logic       carry_flag,
  output logic       zero_flag,
  input  logic [2:0] dbg_sel,
  output logic [7:0] dbg_data
);

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_LSH = 3'd3;
  localparam logic [2:0] OP_LDI = 3'd4;
  localparam logic [2:0] OP_LDM = 3'd5;
  localparam logic [2:0] OP_STR = 3'd6;
  // Op code 3'd7 is unused and retires as a NOP.

  localparam logic [7:0] TIMER_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  state_t     state_q;
  logic [8:0] instr_q;
  logic [7:0] result_q;
  logic [7:0] timer_q;
  logic       timeout_q;
  logic       carry_q;
  logic       zero_q;
  logic [7:0] regs_q [8];

  logic [2:0] op;
  logic [2:0] ra;
  logic [2:0] rb;
  logic [7:0] ra_val;
  logic [7:0] rb_val;
  logic       op_is_mem;
  logic       op_writes;
  logic       op_sets_zero;
  logic       rf_we;

  assign op     = instr_q[8:6];
  assign ra     = instr_q[5:3];
  assign rb     = instr_q[2:0];
  assign ra_val = regs_q[ra];
  assign rb_val = regs_q[rb];

  assign op_is_mem    = (op == OP_LDM) || (op == OP_STR);
  assign op_sets_zero = (op == OP_AND) || (op == OP_ADD) || (op == OP_XOR) || (op == OP_LSH);
  assign op_writes    = op_sets_zero || (op == OP_LDI) || (op == OP_LDM);

  // A timed-out load has nothing valid in result_q, so it must not retire a write.
  assign rf_we = (state_q == S_WB) && op_writes && !timeout_q;

  assign instr_ready = (state_q == S_IDLE);
  assign done        = (state_q == S_WB);
  assign err         = (state_q == S_WB) && timeout_q;
  assign carry_flag  = carry_q;
  assign zero_flag   = zero_q;
  assign dbg_data    = regs_q[dbg_sel];

  always_comb begin
    alu_op  = 3'd0;
    alu_a   = 8'd0;
    alu_b   = 8'd0;
    alu_ci  = 1'b0;
    alu_rsh = 1'b0;
    if (state_q == S_EXEC) begin
      alu_op = op;
      alu_a  = ra_val;
      alu_ci = (op == OP_ADD) ? carry_q : 1'b0;
      case (op)
        OP_LDI: alu_b = {5'b0, rb};
        OP_LSH: begin
          alu_b   = {6'b0, rb[1:0]};
          alu_rsh = rb[2];
        end
        default: alu_b = rb_val;
      endcase
    end
  end

  // Register file is not written while in MEM, so these stay stable until exit.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 8'd0;
    mem_wdata = 8'd0;
    if (state_q == S_MEM) begin
      mem_req  = 1'b1;
      mem_addr = rb_val;
      if (op == OP_STR) begin
        mem_we    = 1'b1;
        mem_wdata = result_q;
      end
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      instr_q   <= 9'd0;
      result_q  <= 8'd0;
      timer_q   <= 8'd0;
      timeout_q <= 1'b0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            instr_q   <= instr;
            timeout_q <= 1'b0;
            state_q   <= S_EXEC;
          end
        end
        S_EXEC: begin
          result_q <= alu_rslt;
          timer_q  <= 8'd0;
          if (op == OP_ADD) carry_q <= alu_co;
          if (op_sets_zero) zero_q <= alu_z;
          state_q <= op_is_mem ? S_MEM : S_WB;
        end
        S_MEM: begin
          // An ack on the last allowed cycle still wins over the timeout.
          if (mem_ack) begin
            if (op == OP_LDM) result_q <= mem_rdata;
            timer_q <= 8'd0;
            state_q <= S_WB;
          end else if (timer_q == TIMER_LAST) begin
            timeout_q <= 1'b1;
            timer_q   <= 8'd0;
            state_q   <= S_WB;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        S_WB: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_rf
    always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
        regs_q[gi] <= 8'd0;
      end else if (rf_we && (ra == 3'(gi))) begin
        regs_q[gi] <= result_q;
      end
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: behavioural ALU and memory responder, a vector table of
// instructions, a done/err scoreboard, and hand-written reset corner cases.
`timescale 1ns/100ps
module tb_instr_sequencer;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_LSH = 3'd3;
  localparam logic [2:0] OP_LDI = 3'd4;
  localparam logic [2:0] OP_LDM = 3'd5;
  localparam logic [2:0] OP_STR = 3'd6;
  localparam logic [2:0] OP_NOP = 3'd7;
  localparam int TIMEOUT = 15;

  logic       CLK = 1'b0;
  logic       reset_n;
  logic       instr_valid;
  logic [8:0] instr;
  logic       instr_ready;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b;
  logic       alu_ci, alu_rsh;
  logic [7:0] alu_rslt;
  logic       alu_co, alu_z;
  logic       mem_req, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_ack;
  logic       done, err;
  logic       carry_flag, zero_flag;
  logic [2:0] dbg_sel;
  logic [7:0] dbg_data;

  always #10 CLK = ~CLK;

  instr_sequencer #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .reset_n(reset_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ci(alu_ci), .alu_rsh(alu_rsh), .alu_rslt(alu_rslt), .alu_co(alu_co),
    .alu_z(alu_z), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .done(done),
    .err(err), .carry_flag(carry_flag), .zero_flag(zero_flag), .dbg_sel(dbg_sel),
    .dbg_data(dbg_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ALU: store passes A through; unknown ops return ~A so a stray write is visible.
  always_comb begin
    logic [8:0] sum;
    sum      = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_ci};
    alu_co   = 1'b0;
    case (alu_op)
      OP_AND:  alu_rslt = alu_a & alu_b;
      OP_ADD:  begin alu_rslt = sum[7:0]; alu_co = sum[8]; end
      OP_XOR:  alu_rslt = alu_a ^ alu_b;
      OP_LSH:  alu_rslt = alu_rsh ? (alu_a >> alu_b) : (alu_a << alu_b);
      OP_LDI:  alu_rslt = alu_b;
      OP_STR:  alu_rslt = alu_a;
      default: alu_rslt = ~alu_a;
    endcase
    alu_z = (alu_rslt == 8'd0);
  end

  // Memory responder: ack on the ack_after-th MEM cycle (0 = never).
  int         ack_after = 0;
  int         mem_cnt = 0;
  logic [7:0] rd_val = 8'd0;
  logic       stray_ack = 1'b0;

  always @(posedge CLK) mem_cnt <= mem_req ? mem_cnt + 1 : 0;

  always_comb begin
    mem_ack   = stray_ack || (mem_req && ack_after > 0 && mem_cnt == ack_after - 1);
    mem_rdata = mem_ack ? rd_val : 8'hEE;
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    logic err;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  logic [7:0] exp_addr = 8'd0;
  logic [7:0] exp_wdata = 8'd0;
  logic       exp_we = 1'b0;

  always @(negedge CLK) begin
    if (reset_n) begin
      if (done) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0 cyc=%0d", cyc);
        end else begin
          mon_e = sb_q.pop_front();
          check("done_cycle", cyc, mon_e.cyc);
          check("err", err, mon_e.err);
        end
        check("alu_idle_in_wb", {alu_op, alu_a, alu_b, alu_ci, alu_rsh}, 0);
      end else if (err) begin
        check("err_without_done", err, 0);
      end
      if (mem_req) begin
        check("mem_addr", mem_addr, exp_addr);
        check("mem_we", mem_we, exp_we);
        if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
      end else begin
        check("mem_idle", {mem_we, mem_addr, mem_wdata}, 0);
      end
    end
  end

  typedef struct {
    logic [2:0] op;
    logic [2:0] ra;
    logic [2:0] rb;
    int         k;
    logic [7:0] rdata;
    logic [7:0] exp_val;
    logic       exp_c;
    logic       exp_z;
    logic       exp_err;
    logic [7:0] addr;
    logic       we;
    logic [7:0] wdata;
  } vec_t;

  vec_t       vecs[21];
  logic [7:0] model_r[8];

  task automatic run(input vec_t v, input string tag);
    int  n;
    int  keff;
    bit  seen;
    n = 0;
    while (!instr_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_ready_wait"}, instr_ready, 1);
    ack_after = v.k;
    rd_val    = v.rdata;
    exp_addr  = v.addr;
    exp_we    = v.we;
    exp_wdata = v.wdata;
    dbg_sel   = v.ra;
    if (v.op == OP_LDM || v.op == OP_STR)
      keff = (v.k == 0 || v.k > TIMEOUT) ? TIMEOUT : v.k;
    else
      keff = 0;
    sb_q.push_back('{cyc + 2 + keff, v.exp_err});
    instr       = {v.op, v.ra, v.rb};
    instr_valid = 1'b1;
    @(posedge CLK);
    #1;
    instr_valid = 1'b0;
    instr       = 9'h1FF;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge CLK);
      if (done) begin
        seen = 1'b1;
        check({tag, "_dbg_pre_write"}, dbg_data, model_r[v.ra]);
      end
    end
    check({tag, "_done_seen"}, seen, 1);
    @(negedge CLK);
    check({tag, "_ready_after"}, instr_ready, 1);
    check({tag, "_reg"}, dbg_data, v.exp_val);
    check({tag, "_carry"}, carry_flag, v.exp_c);
    check({tag, "_zero"}, zero_flag, v.exp_z);
    model_r[v.ra] = v.exp_val;
    $display("vec %s op=%0d ra=%0d rb=%0d k=%0d -> R%0d=%02h c=%0b z=%0b err=%0b",
             tag, v.op, v.ra, v.rb, v.k, v.ra, dbg_data, carry_flag, zero_flag, v.exp_err);
  endtask

  task automatic check_regs_zero(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i);
      #1;
      check($sformatf("%s_R%0d", tag, i), dbg_data, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    instr_valid = 1'b0;
    instr       = 9'd0;
    dbg_sel     = 3'd0;
    for (int i = 0; i < 8; i++) model_r[i] = 8'd0;

    //           op      ra rb  k   rdata  exp    c  z  err addr   we wdata
    vecs[0]  = '{OP_LDI, 1, 5,  0, 8'h00, 8'h05, 0, 0, 0, 8'h00, 0, 8'h00};
    vecs[1]  = '{OP_LDI, 2, 3,  0, 8'h00, 8'h03, 0, 0, 0, 8'h00, 0, 8'h00};
    vecs[2]  = '{OP_ADD, 1, 2,  0, 8'h00, 8'h08, 0, 0, 0, 8'h00, 0, 8'h00};
    vecs[3]  = '{OP_LDM, 1, 0,  2, 8'hFF, 8'hFF, 0, 0, 0, 8'h00, 0, 8'h00};
    vecs[4]  = '{OP_LDI, 2, 1,  0, 8'h00, 8'h01, 0, 0, 0, 8'h00, 0, 8'h00};
    vecs[5]  = '{OP_ADD, 1, 2,  0, 8'h00, 8'h00, 1, 1, 0, 8'h00, 0, 8'h00};
    vecs[6]  = '{OP_ADD, 3, 3,  0, 8'h00, 8'h01, 0, 0, 0, 8'h00, 0, 8'h00};
    vecs[7]  = '{OP_LDM, 4, 0,  1, 8'h2A, 8'h2A, 0, 0, 0, 8'h00, 0, 8'h00};
    vecs[8]  = '{OP_LDM, 5, 0,  1, 8'h10, 8'h10, 0, 0, 0, 8'h00, 0, 8'h00};
    vecs[9]  = '{OP_STR, 4, 5,  3, 8'h00, 8'h2A, 0, 0, 0, 8'h10, 1, 8'h2A};
    vecs[10] = '{OP_LDM, 6, 0,  0, 8'h55, 8'h00, 0, 0, 1, 8'h00, 0, 8'h00};
    vecs[11] = '{OP_LDM, 6, 0, 15, 8'h81, 8'h81, 0, 0, 0, 8'h00, 0, 8'h00};
    vecs[12] = '{OP_LSH, 6, 5,  0, 8'h00, 8'h40, 0, 0, 0, 8'h00, 0, 8'h00};
    vecs[13] = '{OP_LDM, 6, 0,  1, 8'h81, 8'h81, 0, 0, 0, 8'h00, 0, 8'h00};
    vecs[14] = '{OP_LSH, 6, 1,  0, 8'h00, 8'h02, 0, 0, 0, 8'h00, 0, 8'h00};
    vecs[15] = '{OP_XOR, 6, 6,  0, 8'h00, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00};
    vecs[16] = '{OP_AND, 4, 5,  0, 8'h00, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00};
    vecs[17] = '{OP_NOP, 4, 4,  0, 8'h00, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00};
    vecs[18] = '{OP_LDM, 4, 0,  1, 8'h2A, 8'h2A, 0, 1, 0, 8'h00, 0, 8'h00};
    vecs[19] = '{OP_AND, 4, 4,  0, 8'h00, 8'h2A, 0, 0, 0, 8'h00, 0, 8'h00};
    vecs[20] = '{OP_LDI, 7, 6,  0, 8'h00, 8'h06, 0, 0, 0, 8'h00, 0, 8'h00};

    // Reset state while held in reset.
    repeat (2) @(negedge CLK);
    check("rst_ready", instr_ready, 1);
    check("rst_done_err", {done, err}, 0);
    check("rst_mem", {mem_req, mem_we, mem_addr, mem_wdata}, 0);
    check("rst_alu", {alu_op, alu_a, alu_b, alu_ci, alu_rsh}, 0);
    check("rst_flags", {carry_flag, zero_flag}, 0);
    check_regs_zero("rst");
    @(negedge CLK);
    #1 reset_n = 1'b1;
    @(negedge CLK);
    check("ready_first_cycle", instr_ready, 1);

    // A stray mem_ack in IDLE must not move the sequencer.
    stray_ack = 1'b1;
    repeat (3) @(negedge CLK);
    stray_ack = 1'b0;
    check("stray_ack_idle", {instr_ready, done, mem_req}, 3'b100);

    for (int i = 0; i < 20; i++) run(vecs[i], $sformatf("v%0d", i));

    // Asynchronous reset in the middle of a store's MEM phase.
    ack_after = 0;
    exp_addr  = model_r[5];
    exp_we    = 1'b1;
    exp_wdata = model_r[4];
    instr       = {OP_STR, 3'd4, 3'd5};
    instr_valid = 1'b1;
    @(posedge CLK);
    #1;
    instr_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("midmem_req_before", mem_req, 1);
    #2 reset_n = 1'b0;
    #1;
    check("midmem_req_dropped", {mem_req, mem_we, mem_addr, mem_wdata}, 0);
    check("midmem_no_done", {done, err}, 0);
    check("midmem_ready", instr_ready, 1);
    @(negedge CLK);
    check_regs_zero("midmem");
    check("midmem_flags", {carry_flag, zero_flag}, 0);
    @(negedge CLK);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 8; i++) model_r[i] = 8'd0;
    @(negedge CLK);
    check("midmem_ready_after", instr_ready, 1);
    $display("seq mid_mem_reset: mem_req dropped, registers cleared");

    run(vecs[20], "post_reset");

    repeat (3) @(negedge CLK);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
